// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DIV_WIDTH_DEFAULT = 4;

  // Step counter must hold WIDTH itself so it never wraps mid-division.
  function automatic int unsigned step_cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/seq_divider_trial_subtractor.sv
// N-bit ripple subtractor (a + ~b + 1) producing difference and borrow-out.
module trial_subtractor #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  logic carry_out;

  always_comb begin
    logic [N:0] carry;
    carry    = '0;
    carry[0] = 1'b1;
    diff_o   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      diff_o[i]  = a_i[i] ^ ~b_i[i] ^ carry[i];
      carry[i+1] = (a_i[i] & ~b_i[i]) | (carry[i] & (a_i[i] ^ ~b_i[i]));
    end
    carry_out = carry[N];
  end

  assign borrow_o = ~carry_out;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_DBZ_EN for the single-cycle divide-by-zero path and div_by_zero flag.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned   CW        = step_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH:0]   r_q, r_shift, r_d, trial;
  logic [WIDTH-1:0] q_q, q_d, dvsr_q, quot_q, rem_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, dbz_q, borrow;
  logic             unused_r_msb;

  // The partial remainder stays below the divisor, so its top bit is never shifted out.
  assign unused_r_msb = r_q[WIDTH];

  assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  trial_subtractor #(
    .N(WIDTH + 1)
  ) u_trial (
    .a_i     (r_shift),
    .b_i     ({1'b0, dvsr_q}),
    .diff_o  (trial),
    .borrow_o(borrow)
  );

  assign r_d = borrow ? r_shift : trial;
  assign q_d = {q_q[WIDTH-2:0], ~borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RUN: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quot_q  <= q_d;
            rem_q   <= r_d[WIDTH-1:0];
            dbz_q   <= 1'b0;
          end
        end
        default: begin
          // IDLE and DONE both accept a request, giving back-to-back operation.
          if (start) begin
            r_q    <= '0;
            q_q    <= dividend;
            dvsr_q <= divisor;
            cnt_q  <= '0;
`ifdef SEQ_DIVIDER_DBZ_EN
            if (divisor == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              quot_q  <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
`else
            state_q <= RUN;
            busy_q  <= 1'b1;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver queues expected results, a negedge monitor checks them.
module tb_seq_divider;

  localparam int unsigned W = 4;
`ifdef SEQ_DIVIDER_DBZ_EN
  localparam bit DBZ = 1'b1;
`else
  localparam bit DBZ = 1'b0;
`endif

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         start    = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor  = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int unsigned  due;
  } exp_t;

  exp_t         sb[$];
  exp_t         mx;
  int unsigned  edge_cnt  = 0;
  int unsigned  next_ok   = 0;
  int unsigned  busy_from = 1;
  int unsigned  busy_to   = 0;
  logic [W-1:0] last_q    = '0;
  logic [W-1:0] last_r    = '0;
  logic         last_z    = 1'b0;
  int           n_tests   = 0;
  int           n_fail    = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, edge_cnt, act, exp);
    end
  endtask

  // Drive one cycle of inputs; if the divider is free at the sampling edge and start=1,
  // the request is accepted and its result is queued. junk randomises ignored cycles.
  task automatic drive(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit junk, output bit acc);
    int unsigned e;
    exp_t x;
    @(negedge clk);
    e   = edge_cnt + 1;
    acc = s && (e >= next_ok);
    if (junk && e < next_ok) begin
      start    = 1'($urandom);
      dividend = W'($urandom);
      divisor  = W'($urandom);
    end else begin
      start    = s;
      dividend = a;
      divisor  = b;
    end
    if (acc) begin
      x.z = DBZ && (b == 0);
      if (b == 0) begin
        x.q = '1;
        x.r = a;
      end else begin
        x.q = a / b;
        x.r = a % b;
      end
      x.due = x.z ? e : e + W;
      sb.push_back(x);
      if (!x.z) begin
        busy_from = e;
        busy_to   = e + W - 1;
      end
      next_ok = x.z ? e + 1 : e + W + 1;
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) drive(1'b1, a, b, 1'b1, acc);
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: request %0d/%0d never accepted", a, b);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    last_q    = '0;
    last_r    = '0;
    last_z    = 1'b0;
    next_ok   = 0;
    busy_from = 1;
    busy_to   = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_quotient"}, 32'(quotient), 32'd0);
    check({tag, "_remainder"}, 32'(remainder), 32'd0);
    check({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].due < edge_cnt) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL done_timeout: no done by edge %0d, got none, expected q=%0d r=%0d",
                 sb[0].due, sb[0].q, sb[0].r);
        void'(sb.pop_front());
      end
      check("busy", 32'(busy), 32'(edge_cnt >= busy_from && edge_cnt <= busy_to));
      if (done) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL spurious_done at edge %0d: got done=1, expected done=0", edge_cnt);
        end else begin
          mx = sb.pop_front();
          check("latency_edge", edge_cnt, mx.due);
          check("quotient", 32'(quotient), 32'(mx.q));
          check("remainder", 32'(remainder), 32'(mx.r));
          check("div_by_zero", 32'(div_by_zero), 32'(mx.z));
          last_q = mx.q;
          last_r = mx.r;
          last_z = mx.z;
        end
      end else begin
        check("quotient_hold", 32'(quotient), 32'(last_q));
        check("remainder_hold", 32'(remainder), 32'(last_r));
        check("dbz_hold", 32'(div_by_zero), 32'(last_z));
      end
    end
  end

  initial begin
    bit acc;
    #3;
    check_zero_outputs("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;

    send(4'd13, 4'd4);
    send(4'd15, 4'd1);
    send(4'd3,  4'd7);
    send(4'd9,  4'd0);

    // Second start while busy must be ignored.
    send(4'd12, 4'd5);
    drive(1'b0, '0, '0, 1'b0, acc);
    drive(1'b1, 4'd7, 4'd2, 1'b0, acc);
    repeat (4) drive(1'b0, '0, '0, 1'b0, acc);

    // start held high through busy: only the DONE-cycle sample is accepted.
    send(4'd14, 4'd3);
    repeat (W + 1) drive(1'b1, 4'd10, 4'd3, 1'b0, acc);
    drive(1'b0, '0, '0, 1'b0, acc);

    for (int a = 0; a < (1 << W); a++)
      for (int b = 0; b < (1 << W); b++)
        send(W'(a), W'(b));

    for (int i = 0; i < 200; i++)
      drive($urandom_range(0, 2) == 0, W'($urandom), W'($urandom), 1'b0, acc);

    // Abort mid-division with reset, then restart immediately after release.
    send(4'd11, 4'd2);
    drive(1'b0, '0, '0, 1'b0, acc);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs("abort");
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    send(4'd6, 4'd3);

    for (int t = 0; t < 40 && sb.size() > 0; t++) drive(1'b0, '0, '0, 1'b0, acc);
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential unsigned restoring divider.
- Computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock.
- Each step is a trial subtraction of the divisor from the shifted partial remainder, which is kept only when it does not borrow.
- Sits beside the combinational adder-subtractor in the arithmetic library as the multi-cycle divide unit.
- Driven by a start/done handshake from the controlling datapath.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on rising clk; accepted only when busy=0
- dividend  input  WIDTH  numerator, sampled with accepted start
- divisor  input  WIDTH  denominator, sampled with accepted start
- busy  output  1  high while a division is in progress
- done  output  1  single-cycle pulse: results valid
- quotient  output  WIDTH  result quotient, held until next accepted start completes
- remainder  output  WIDTH  result remainder, held likewise
- div_by_zero  output  1  high with done when divisor was 0 (macro-dependent); held with results

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0.
  - start=1 loads the operands, clears the partial remainder R (WIDTH+1 bits) and the step counter, then goes to RUN.
- RUN, one step per cycle:
  - R ← {R[WIDTH-1:0], Q msb}; Q shifts left.
  - Trial T = R − {0,divisor} over WIDTH+1 bits.
  - If there is no borrow: R ← T and the new Q lsb = 1; otherwise R is unchanged and the lsb = 0.
  - After WIDTH steps, go to DONE.
- DONE: quotient ← Q, remainder ← R[WIDTH-1:0], done=1, busy=0.
  - Next state is IDLE, or RUN if start=1 in this cycle (back-to-back accepted).
- start while busy=1 is ignored entirely; the operand inputs are don't-care.
- Divisor 0 by pure restoring arithmetic: quotient = all ones, remainder = dividend. This is required in both configurations.
- Results always satisfy dividend = quotient·divisor + remainder with remainder < divisor (divisor≠0).

## Timing
- start accepted at edge k → busy=1 from cycle k+1 through k+WIDTH.
- done=1 in cycle k+WIDTH+1, for exactly one cycle.
- Latency is WIDTH+1 cycles (5 for WIDTH=4). The divide-by-zero fast path takes 1 cycle (see Configuration).
- quotient/remainder/div_by_zero update only on entry to DONE; they are stable at all other times.
- Reset values: state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- rst_n low mid-operation aborts immediately, with no done pulse. After release the block accepts start on the first clock edge.
- Step counter is $clog2(WIDTH)+1 bits and never wraps during a division.

## Configuration
- SEQ_DIVIDER_DBZ_EN defined:
  - divisor==0 at accepted start skips RUN and goes directly to DONE.
  - done is asserted in cycle k+1 with quotient = all ones, remainder = dividend, div_by_zero=1.
- Undefined:
  - No fast path; zero divisor runs the full WIDTH steps and produces the same quotient/remainder.
  - div_by_zero is tied to 0.

## Structure
- Package seq_divider_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - default width constant DIV_WIDTH_DEFAULT = 4
  - step-counter width function
- One sub-module, trial_subtractor: parameterised N-bit ripple subtractor (a + ~b + 1) with difference and borrow outputs.
  - Instantiated once with N = WIDTH+1 for the trial step.
- FSM, shift registers and result registers live in seq_divider.

## Test plan
- WIDTH=4: start with 13/4 at edge k → done in cycle k+5, quotient=3, remainder=1, busy high in cycles k+1..k+4.
- 15/1 → quotient=15, remainder=0. 3/7 → quotient=0, remainder=3. Sweep all 256 operand pairs against the reference model.
- 9/0: with SEQ_DIVIDER_DBZ_EN → done at k+1, quotient=15, remainder=9, div_by_zero=1. Without it → done at k+5, same values, div_by_zero=0.
- Start 12/5, then pulse start with 7/2 at k+2 → second request ignored; done at k+5 with quotient=2, remainder=2 only.
- Start 14/3, hold start=1 with 10/3 in the DONE cycle → first done: q=4, r=2; second done 5 cycles later: q=3, r=1.
- Assert rst_n=0 at k+2 of a 11/2 division → busy/done/quotient/remainder read 0 immediately. After release, 6/3 completes with q=2, r=0 and latency 5.
